// File: rtl/puf_pkg.sv
// puf_pkg: shared types and defaults for the arbiter-PUF evaluation controller.
//   puf_state_t      : controller state encoding
//   C_LENGTH/C_SETTLE/C_HOLD/C_VOTES : default parameter values
//   cnt_w(n)         : bits needed to hold the values 0..n
package puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FIRE,
        S_RELAX,
        S_DONE
    } puf_state_t;

    localparam int C_LENGTH = 32;
    localparam int C_SETTLE = 4;
    localparam int C_HOLD   = 8;
    localparam int C_VOTES  = 5;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   iclk : clock
//   irst : synchronous reset, active-high; clears both flops
//   id   : asynchronous input
//   oq   : synchronized output (two cycles of latency)
module sync_2ff (
    input  logic iclk,
    input  logic irst,
    input  logic id,
    output logic oq
);

    logic [1:0] sync_pipe;

    always_ff @(posedge iclk) begin
        if (irst) sync_pipe <= '0;
        else      sync_pipe <= {sync_pipe[0], id};
    end

    assign oq = sync_pipe[1];

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequencing controller for the arbiter-PUF delay line.
// Accepts a challenge, drives it onto the mux chain, fires C_VOTES races
// separated by settle gaps, samples the synchronized arbiter output at the
// end of each race and returns a majority-voted response with its ones-count.
//
// Ports:
//   iclk, irst            : clock, synchronous active-high reset
//   ivalid/oready         : challenge handshake, ichallenge = challenge word
//   iabort                : cancel an evaluation in progress
//   opulse, ochallenge    : race pulse and registered challenge to delay line
//   iarb                  : arbiter decision, asynchronous to iclk
//   ovalid/iready         : response handshake
//   oresp, oones          : voted response bit and number of races returning 1
//   ostable               : unanimity flag (only with PUF_STABILITY_EN)
//
// Optional feature macro: PUF_STABILITY_EN adds the ostable output.
module puf_eval_ctrl #(
    parameter int C_LENGTH = puf_pkg::C_LENGTH,
    parameter int C_SETTLE = puf_pkg::C_SETTLE,
    parameter int C_HOLD   = puf_pkg::C_HOLD,
    parameter int C_VOTES  = puf_pkg::C_VOTES
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic                         ivalid,
    input  logic [C_LENGTH-1:0]          ichallenge,
    output logic                         oready,
    input  logic                         iabort,
    output logic                         opulse,
    output logic [C_LENGTH-1:0]          ochallenge,
    input  logic                         iarb,
    output logic                         ovalid,
    input  logic                         iready,
    output logic                         oresp,
`ifdef PUF_STABILITY_EN
    output logic                         ostable,
`endif
    output logic [$clog2(C_VOTES+1)-1:0] oones
);

    import puf_pkg::*;

    localparam int PH_MAX = (C_SETTLE > C_HOLD) ? C_SETTLE : C_HOLD;
    localparam int PH_W   = cnt_w(PH_MAX);
    localparam int OW     = $clog2(C_VOTES + 1);

    puf_state_t      state;
    logic [PH_W-1:0] ph_cnt;   // remaining cycles in SETTLE/FIRE/RELAX
    logic [OW-1:0]   votes;    // races completed so far
    logic            arb_s;

    sync_2ff u_sync (
        .iclk (iclk),
        .irst (irst),
        .id   (iarb),
        .oq   (arb_s)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= S_IDLE;
            ph_cnt     <= '0;
            votes      <= '0;
            oready     <= 1'b1;
            opulse     <= 1'b0;
            ochallenge <= '0;
            ovalid     <= 1'b0;
            oresp      <= 1'b0;
            oones      <= '0;
`ifdef PUF_STABILITY_EN
            ostable    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ivalid) begin
                        ochallenge <= ichallenge;
                        oones      <= '0;
                        votes      <= '0;
                        oresp      <= 1'b0;
`ifdef PUF_STABILITY_EN
                        ostable    <= 1'b0;
`endif
                        oready     <= 1'b0;
                        ph_cnt     <= PH_W'(C_SETTLE - 1);
                        state      <= S_SETTLE;
                    end
                end

                S_SETTLE, S_FIRE, S_RELAX: begin
                    // Abort takes priority over any phase transition, so a
                    // sample on the final FIRE edge is dropped.
                    if (iabort) begin
                        opulse <= 1'b0;
                        oready <= 1'b1;
                        state  <= S_IDLE;
                    end else if (ph_cnt != '0) begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end else begin
                        case (state)
                            S_SETTLE: begin
                                opulse <= 1'b1;
                                ph_cnt <= PH_W'(C_HOLD - 1);
                                state  <= S_FIRE;
                            end
                            S_FIRE: begin
                                opulse <= 1'b0;
                                oones  <= oones + OW'(arb_s);
                                votes  <= votes + OW'(1);
                                ph_cnt <= PH_W'(C_SETTLE - 1);
                                state  <= S_RELAX;
                            end
                            default: begin  // S_RELAX
                                if (votes < OW'(C_VOTES)) begin
                                    opulse <= 1'b1;
                                    ph_cnt <= PH_W'(C_HOLD - 1);
                                    state  <= S_FIRE;
                                end else begin
                                    ovalid  <= 1'b1;
                                    oresp   <= (oones > OW'(C_VOTES / 2));
`ifdef PUF_STABILITY_EN
                                    ostable <= (oones == '0) || (oones == OW'(C_VOTES));
`endif
                                    state   <= S_DONE;
                                end
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    if (iready) begin
                        ovalid <= 1'b0;
                        oready <= 1'b1;
                        state  <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
